// File: rtl/fp16_divider_seq.sv
// Iterative IEEE-754 half-precision divider (in1 / in2): restoring division,
// one quotient bit per clock, truncating rounding, subnormals flushed to zero.
module fp16_divider_seq #(
    parameter logic [15:0] NaN_OUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    localparam int ITER = 12;

    typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

    state_t      state, state_n;
    logic [11:0] rem;
    logic [10:0] dvs;
    logic [11:0] q;
    logic [3:0]  cnt;
    logic [4:0]  e1, e2;
    logic        sgn;
    logic        spec;
    logic [15:0] spec_res;

    logic [4:0]  ea, eb;
    logic [9:0]  ma, mb;
    logic        s, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic        is_spec;
    logic [15:0] spec_val;

    assign ea     = in1[14:10];
    assign eb     = in2[14:10];
    assign ma     = in1[9:0];
    assign mb     = in2[9:0];
    assign s      = in1[15] ^ in2[15];
    assign zero_a = (ea == 5'd0);
    assign zero_b = (eb == 5'd0);
    assign inf_a  = (ea == 5'h1F) && (ma == 10'd0);
    assign inf_b  = (eb == 5'h1F) && (mb == 10'd0);
    assign nan_a  = (ea == 5'h1F) && (ma != 10'd0);
    assign nan_b  = (eb == 5'h1F) && (mb != 10'd0);

    // Special-case priority matters: NaN and indeterminate forms win first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        is_spec  = 1'b1;
        spec_val = 16'h0000;
        if (nan_a || nan_b)                          spec_val = NaN_OUT;
        else if ((inf_a && inf_b) || (zero_a && zero_b)) spec_val = NaN_OUT;
        else if (inf_a || zero_b)                    spec_val = {s, 5'h1F, 10'h000};
        else if (zero_a || inf_b)                    spec_val = {s, 15'h0000};
        else                                         is_spec = 1'b0;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = is_spec ? NORM : CALC;
            CALC:    if (cnt == 4'd0) state_n = NORM;
            NORM:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    logic        ge;
    logic [11:0] diff;
    assign ge   = (rem >= {1'b0, dvs});
    assign diff = ge ? (rem - {1'b0, dvs}) : rem;

    // Quotient lies in [0.5, 2) scaled by 2^11; q[11] selects the normalisation shift.
    logic signed [6:0] exp_n;
    logic [9:0]        mant;
    logic [15:0]       norm_val;
    always_comb begin
        exp_n = $signed({2'b00, e1}) - $signed({2'b00, e2}) + (q[11] ? 7'sd15 : 7'sd14);
        mant  = q[11] ? q[10:1] : q[9:0];
        if (exp_n >= 7'sd31)     norm_val = {sgn, 5'h1F, 10'h000};
        else if (exp_n <= 7'sd0) norm_val = {sgn, 15'h0000};
        else                     norm_val = {sgn, exp_n[4:0], mant};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            dvs      <= '0;
            q        <= '0;
            cnt      <= '0;
            e1       <= '0;
            e2       <= '0;
            sgn      <= 1'b0;
            spec     <= 1'b0;
            spec_res <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sgn      <= s;
                    e1       <= ea;
                    e2       <= eb;
                    rem      <= {2'b01, ma};
                    dvs      <= {1'b1, mb};
                    cnt      <= 4'(ITER - 1);
                    q        <= '0;
                    spec     <= is_spec;
                    spec_res <= spec_val;
                end
                CALC: begin
                    q   <= {q[10:0], ge};
                    rem <= diff << 1;
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                NORM: begin
                    result <= spec ? spec_res : norm_val;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_divider_seq.sv
// Directed self-checking bench for fp16_divider_seq with hand-computed quotients.
module tb_fp16_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in1, in2;
    logic        busy, done;
    logic [15:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    fp16_divider_seq dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge; leaves the bench in the done cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                          input int lat, input string tag);
        int n;
        int bc;
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, 32'(result), 32'(exp));
        if (lat == 13) check({tag, " busy_cycles"}, 32'(bc), 32'd13);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'h0000);
        rst = 1'b0;
        idle(2);

        run_op(16'h4600, 16'h4000, 16'h4200, 13, "6/2");
        @(posedge clk); #1;
        check("6/2 done_pulse_drops", 32'(done), 32'd0);
        check("6/2 result_held", 32'(result), 32'h4200);
        idle(1);

        run_op(16'hC400, 16'h4000, 16'hC000, 13, "-4/2");
        idle(1);
        run_op(16'h3C00, 16'h4200, 16'h3555, 13, "1/3");
        run_op(16'h4000, 16'h3C00, 16'h4000, 13, "b2b 2/1");
        idle(1);

        run_op(16'h3C00, 16'h0000, 16'h7C00, 1, "x/0");
        idle(1);
        run_op(16'h0000, 16'h0000, 16'hFFFF, 1, "0/0");
        idle(1);
        run_op(16'h7C00, 16'h7C00, 16'hFFFF, 1, "inf/inf");
        idle(1);
        run_op(16'hFFFF, 16'h3C00, 16'hFFFF, 1, "nan/x");
        idle(1);
        run_op(16'h0000, 16'hBC00, 16'h8000, 1, "0/-1");
        idle(1);

        run_op(16'h7BFF, 16'h0400, 16'h7C00, 13, "overflow");
        idle(1);
        run_op(16'h0400, 16'h7BFF, 16'h0000, 13, "underflow");
        idle(1);

        // Operand changes and a second start while busy must not disturb the operation.
        fork
            run_op(16'h4600, 16'h4000, 16'h4200, 13, "busy_protect");
            begin
                repeat (4) @(posedge clk);
                #2;
                in1 = 16'h3C00; in2 = 16'h4200; start = 1'b1;
                @(posedge clk); #2;
                start = 1'b0;
            end
        join
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("busy_protect extra_done", 32'(dones), 32'd0);

        // Asynchronous reset in the middle of CALC.
        in1 = 16'h4600; in2 = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", 32'(result), 32'h0000);
        #1 rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst no_done", 32'(dones), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
